// File: rtl/mio_bus_arbiter.sv
// Two-master arbiter for the MIO bus master port: round-robin grant, one
// transaction at a time, fixed read-return latency of RD_LAT cycles.
module mio_bus_arbiter #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned AW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_ack,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_ack,
    output logic [31:0]   m1_rdata,
    output logic          mem_w,
    output logic [AW-1:0] addr_bus,
    output logic [31:0]   Cpu_data2bus,
    input  logic [31:0]   Cpu_data4bus,
    output logic          busy,
    output logic          owner
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_d;
    logic          rr_ptr, rr_ptr_d;
    logic          owner_d;
    logic          lat_we, lat_we_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          mem_w_d;
    logic [AW-1:0] addr_bus_d;
    logic [DW-1:0] data2bus_d;
    logic          m0_ack_d, m1_ack_d;
    logic [DW-1:0] m0_rdata_d, m1_rdata_d;
    logic          busy_d;
    logic          grant;
    logic          fin;
    logic [DW-1:0] fin_data;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        owner_d    = owner;
        lat_we_d   = lat_we;
        cnt_d      = cnt;
        mem_w_d    = 1'b0;
        addr_bus_d = addr_bus;
        data2bus_d = Cpu_data2bus;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata;
        m1_rdata_d = m1_rdata;
        grant      = 1'b0;
        fin        = 1'b0;
        fin_data   = '0;

        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant      = (m0_req && m1_req) ? rr_ptr : m1_req;
                    owner_d    = grant;
                    lat_we_d   = grant ? m1_we : m0_we;
                    addr_bus_d = grant ? m1_addr : m0_addr;
                    data2bus_d = grant ? m1_wdata : m0_wdata;
                    mem_w_d    = grant ? m1_we : m0_we;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (lat_we) begin
                    fin = 1'b1;
                end else if (RD_LAT == 0) begin
                    fin      = 1'b1;
                    fin_data = Cpu_data4bus;
                end else begin
                    cnt_d   = CW'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    fin      = 1'b1;
                    fin_data = Cpu_data4bus;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            RESP: begin
                rr_ptr_d = ~owner;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Completion: registered ack/rdata appear during the RESP cycle
        if (fin) begin
            state_d    = RESP;
            addr_bus_d = '0;
            data2bus_d = '0;
            if (owner) begin
                m1_ack_d   = 1'b1;
                m1_rdata_d = fin_data;
            end else begin
                m0_ack_d   = 1'b1;
                m0_rdata_d = fin_data;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            owner        <= 1'b0;
            lat_we       <= 1'b0;
            cnt          <= '0;
            mem_w        <= 1'b0;
            addr_bus     <= '0;
            Cpu_data2bus <= '0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            rr_ptr       <= rr_ptr_d;
            owner        <= owner_d;
            lat_we       <= lat_we_d;
            cnt          <= cnt_d;
            mem_w        <= mem_w_d;
            addr_bus     <= addr_bus_d;
            Cpu_data2bus <= data2bus_d;
            m0_ack       <= m0_ack_d;
            m1_ack       <= m1_ack_d;
            m0_rdata     <= m0_rdata_d;
            m1_rdata     <= m1_rdata_d;
            busy         <= busy_d;
        end
    end
endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter: RD_LAT=1 instance plus an RD_LAT=0
// instance sharing the same master stimulus.
module tb_mio_bus_arbiter;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata, Cpu_data4bus;

    logic          m0_ack, m1_ack, mem_w, busy, owner;
    logic [31:0]   m0_rdata, m1_rdata, Cpu_data2bus;
    logic [AW-1:0] addr_bus;

    logic          z_m0_ack, z_m1_ack, z_mem_w, z_busy, z_owner;
    logic [31:0]   z_m0_rdata, z_m1_rdata, z_data2bus;
    logic [AW-1:0] z_addr_bus;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mio_bus_arbiter #(.RD_LAT(1), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_w(mem_w), .addr_bus(addr_bus), .Cpu_data2bus(Cpu_data2bus),
        .Cpu_data4bus(Cpu_data4bus), .busy(busy), .owner(owner)
    );

    mio_bus_arbiter #(.RD_LAT(0), .AW(AW)) dut_z (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(z_m0_ack), .m0_rdata(z_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(z_m1_ack), .m1_rdata(z_m1_rdata),
        .mem_w(z_mem_w), .addr_bus(z_addr_bus), .Cpu_data2bus(z_data2bus),
        .Cpu_data4bus(Cpu_data4bus), .busy(z_busy), .owner(z_owner)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        Cpu_data4bus = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [265:0] obs;
        idle_inputs();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            obs = {mem_w, busy, owner, m0_ack, m1_ack, addr_bus, Cpu_data2bus, m0_rdata, m1_rdata,
                   z_mem_w, z_busy, z_owner, z_m0_ack, z_m1_ack, z_addr_bus, z_data2bus,
                   z_m0_rdata, z_m1_rdata};
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %h required 0", i, obs);
            end
            tick();
        end
    endtask

    task automatic test_m0_write();
        m0_we = 1'b1; m0_addr = 32'h0000_0010; m0_wdata = 32'hDEAD_BEEF; m0_req = 1'b1;
        tick();
        checks++;
        if ({mem_w, addr_bus, Cpu_data2bus, owner, busy} !== {1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL wr_issue: got %h required %h", {mem_w, addr_bus, Cpu_data2bus, owner, busy},
                     {1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1});
        end
        checks++;
        if ({m0_ack, m1_ack} !== 2'b00) begin
            errors++;
            $display("FAIL wr_early_ack: got %b required 00", {m0_ack, m1_ack});
        end
        tick();
        checks++;
        if ({mem_w, m0_ack, m1_ack, addr_bus, Cpu_data2bus, m0_rdata} !== {1'b0, 1'b1, 1'b0, 96'h0}) begin
            errors++;
            $display("FAIL wr_resp: got %h required %h", {mem_w, m0_ack, m1_ack, addr_bus, Cpu_data2bus, m0_rdata},
                     {1'b0, 1'b1, 1'b0, 96'h0});
        end
        m0_req = 1'b0;
        tick();
        checks++;
        if ({mem_w, m0_ack, m1_ack, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL wr_done: got %b required 0000", {mem_w, m0_ack, m1_ack, busy});
        end
    endtask

    task automatic test_m1_read();
        m1_we = 1'b0; m1_addr = 32'hF000_0004; m1_wdata = 32'h55AA_55AA;
        Cpu_data4bus = 32'hBAD0_BAD0; m1_req = 1'b1;
        tick();
        checks++;
        if ({mem_w, addr_bus, owner, busy} !== {1'b0, 32'hF000_0004, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL rd_issue: got %h required %h", {mem_w, addr_bus, owner, busy},
                     {1'b0, 32'hF000_0004, 1'b1, 1'b1});
        end
        Cpu_data4bus = 32'h1234_5678;
        tick();
        checks++;
        if ({mem_w, addr_bus, m0_ack, m1_ack, busy} !== {1'b0, 32'hF000_0004, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rd_wait: got %h required %h", {mem_w, addr_bus, m0_ack, m1_ack, busy},
                     {1'b0, 32'hF000_0004, 1'b0, 1'b0, 1'b1});
        end
        tick();
        checks++;
        if ({m1_ack, m1_rdata, m0_ack, m0_rdata, mem_w} !== {1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL rd_resp: got %h required %h", {m1_ack, m1_rdata, m0_ack, m0_rdata, mem_w},
                     {1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0});
        end
        m1_req = 1'b0; Cpu_data4bus = '0;
        tick();
        checks++;
        if ({m1_ack, busy, mem_w} !== 3'b000) begin
            errors++;
            $display("FAIL rd_done: got %b required 000", {m1_ack, busy, mem_w});
        end
    endtask

    task automatic test_back_to_back();
        int wcount;
        int budget;
        logic [2:0] exp;
        idle_inputs();
        do_reset();
        m0_we = 1'b1; m0_addr = 32'h100; m0_wdata = 32'h1111_0000;
        m1_we = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h2222_0000;
        m0_req = 1'b1; m1_req = 1'b1;
        wcount = 0;
        for (int i = 0; i < 6; i++) begin
            budget = 0;
            do begin
                tick();
                if (mem_w) wcount++;
                budget++;
            end while (!(m0_ack || m1_ack) && budget < 8);
            exp = (i % 2 == 1) ? 3'b101 : 3'b010;
            checks++;
            if ({m1_ack, m0_ack, owner} !== exp) begin
                errors++;
                $display("FAIL rr_grant txn %0d: got {m1_ack,m0_ack,owner}=%b required %b", i,
                         {m1_ack, m0_ack, owner}, exp);
            end
            tick();
            if (mem_w) wcount++;
            checks++;
            if ({m1_ack, m0_ack} !== 2'b00) begin
                errors++;
                $display("FAIL ack_one_cycle txn %0d: got %b required 00", i, {m1_ack, m0_ack});
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        checks++;
        if ({busy, 32'(wcount)} !== {1'b0, 32'd6}) begin
            errors++;
            $display("FAIL rr_end: busy=%b mem_w_cycles=%0d required busy=0 mem_w_cycles=6", busy, wcount);
        end
    endtask

    task automatic test_reset_in_wait();
        idle_inputs();
        do_reset();
        m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h1; m0_req = 1'b1;
        tick();
        tick();
        m0_req = 1'b0;
        tick();
        m0_we = 1'b0; m0_addr = 32'h30;
        m1_we = 1'b0; m1_addr = 32'hF000_0008;
        Cpu_data4bus = 32'hCAFE_F00D;
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        checks++;
        if ({owner, addr_bus} !== {1'b1, 32'hF000_0008}) begin
            errors++;
            $display("FAIL rst_pre_owner: got %h required %h", {owner, addr_bus}, {1'b1, 32'hF000_0008});
        end
        tick();
        checks++;
        if ({busy, mem_w, m1_ack} !== 3'b100) begin
            errors++;
            $display("FAIL rst_pre_wait: got %b required 100", {busy, mem_w, m1_ack});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, owner, mem_w, m0_ack, m1_ack, addr_bus, Cpu_data2bus, m0_rdata, m1_rdata} !== '0) begin
            errors++;
            $display("FAIL rst_async_clear: got %h required 0",
                     {busy, owner, mem_w, m0_ack, m1_ack, addr_bus, Cpu_data2bus, m0_rdata, m1_rdata});
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({owner, addr_bus, busy, mem_w, m1_ack} !== {1'b0, 32'h30, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_regrant: got %h required %h", {owner, addr_bus, busy, mem_w, m1_ack},
                     {1'b0, 32'h30, 1'b1, 1'b0, 1'b0});
        end
        tick();
        tick();
        checks++;
        if ({m0_ack, m0_rdata, m1_ack, m1_rdata} !== {1'b1, 32'hCAFE_F00D, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rst_post_resp: got %h required %h", {m0_ack, m0_rdata, m1_ack, m1_rdata},
                     {1'b1, 32'hCAFE_F00D, 1'b0, 32'h0});
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        checks++;
        if ({busy, m0_ack, m1_ack} !== 3'b000) begin
            errors++;
            $display("FAIL rst_post_done: got %b required 000", {busy, m0_ack, m1_ack});
        end
    endtask

    task automatic test_rd_lat0();
        idle_inputs();
        do_reset();
        m0_we = 1'b0; m0_addr = 32'h44; m0_req = 1'b1;
        tick();
        checks++;
        if ({z_mem_w, z_addr_bus, z_busy, z_owner, z_m0_ack} !== {1'b0, 32'h44, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL lat0_issue: got %h required %h", {z_mem_w, z_addr_bus, z_busy, z_owner, z_m0_ack},
                     {1'b0, 32'h44, 1'b1, 1'b0, 1'b0});
        end
        Cpu_data4bus = 32'hA5A5_5A5A;
        tick();
        checks++;
        if ({z_m0_ack, z_m0_rdata, z_m1_ack, z_addr_bus} !== {1'b1, 32'hA5A5_5A5A, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL lat0_resp: got %h required %h", {z_m0_ack, z_m0_rdata, z_m1_ack, z_addr_bus},
                     {1'b1, 32'hA5A5_5A5A, 1'b0, 32'h0});
        end
        checks++;
        if (m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL lat1_not_yet: got m0_ack=%b required 0", m0_ack);
        end
        m0_req = 1'b0; Cpu_data4bus = 32'h0;
        tick();
        checks++;
        if ({z_m0_ack, z_busy, m0_ack, m0_rdata} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL lat_after: got %h required %h", {z_m0_ack, z_busy, m0_ack, m0_rdata},
                     {1'b0, 1'b0, 1'b1, 32'h0});
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_m0_write();
        test_m1_read();
        test_back_to_back();
        test_reset_in_wait();
        test_rd_lat0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
